data_bus_buffer_q: RTL and testbench
====================================

DATA_BUS_BUFFER_Q -- requirements
Module: data_bus_buffer_q

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of CPU and internal data paths.
REQ-002 SHALL have parameter WQ_DEPTH, default 4, write-queue entries; power of two, >= 2.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have CLK  in  1  rising-edge clock.
REQ-005 SHALL have RST_N  in  1  asynchronous active-low reset.
REQ-006 SHALL have CS_N  in  1  chip select, active low.
REQ-007 SHALL have RD_N  in  1  CPU read strobe, active low.
REQ-008 SHALL have WR_N  in  1  CPU write strobe, active low.
REQ-009 SHALL have CAS_SEL  in  1  cascade read enable; permits a read without CS_N.
REQ-010 SHALL have CPU_IN_DATA  in  DATA_W  data written by CPU.
REQ-011 SHALL have CPU_OUT_DATA  out  DATA_W  registered data returned to CPU.
REQ-012 SHALL have CPU_OE  out  1  CPU bus drive enable.
REQ-013 SHALL have INT_IN_DATA  in  DATA_W  internal data for CPU reads.
REQ-014 SHALL have INT_OUT_DATA  out  DATA_W  head of write queue.
REQ-015 SHALL have INT_WR_VALID  out  1  queue non-empty.
REQ-016 SHALL have INT_WR_READY  in  1  internal consumer accepts head.
REQ-017 SHALL have WQ_LEVEL  out  $clog2(WQ_DEPTH+1)  queue occupancy.
REQ-018 SHALL have WQ_FULL  out  1  occupancy == WQ_DEPTH.
REQ-019 SHALL have WQ_OVF  out  1  sticky overflow flag.
REQ-020 SHALL have CLR_OVF  in  1  synchronous clear of WQ_OVF.
REQ-021 SHALL have BUS_ERR  out  1  RD_N and WR_N both low.

Function
REQ-022 SHALL implement bus FSM states IDLE, RD_ACT, WR_ACT, ERR, all inputs sampled at rising CLK.
REQ-023 IDLE -> ERR SHALL occur when RD_N=0 and WR_N=0 (regardless of CS_N/CAS_SEL); ERR -> IDLE only when RD_N=1 and WR_N=1; BUS_ERR=1 exactly while in ERR.
REQ-024 IDLE -> WR_ACT SHALL occur when CS_N=0, WR_N=0, RD_N=1; on that edge CPU_IN_DATA SHALL be pushed once.
REQ-025 WR_ACT SHALL hold while WR_N=0 with no further pushes; WR_N=1 -> IDLE; RD_N=0 while in WR_ACT -> ERR.
REQ-026 IDLE -> RD_ACT SHALL occur when RD_N=0, WR_N=1 and (CS_N=0 or CAS_SEL=1); on that edge CPU_OUT_DATA <= INT_IN_DATA and CPU_OE <= 1.
REQ-027 In RD_ACT, CPU_OUT_DATA SHALL hold the captured value for the whole strobe, ignoring INT_IN_DATA changes.
REQ-028 RD_ACT -> IDLE on RD_N=1, CPU_OE <= 0 on same edge; WR_N=0 while in RD_ACT -> ERR, CPU_OE <= 0.
REQ-029 CPU_OUT_DATA SHALL retain its last value when CPU_OE=0.
REQ-030 Queue SHALL be FIFO; INT_OUT_DATA = head entry, combinational from storage; INT_WR_VALID = (WQ_LEVEL != 0).
REQ-031 Pop SHALL occur on edge where INT_WR_VALID=1 and INT_WR_READY=1.
REQ-032 Push and pop in same edge SHALL both occur, level unchanged, including when full.
REQ-033 Push when full without pop SHALL discard data, leave queue unchanged, set WQ_OVF.
REQ-034 Pointers SHALL wrap modulo WQ_DEPTH; INT_WR_READY with empty queue SHALL have no effect.
REQ-035 WQ_OVF SHALL clear on CLR_OVF=1; simultaneous set and clear SHALL leave WQ_OVF=1.
REQ-036 Push-to-INT_WR_VALID latency SHALL be one edge (visible after the push edge).

Reset
REQ-037 RST_N=0 SHALL immediately force: FSM IDLE, CPU_OE=0, CPU_OUT_DATA=0, BUS_ERR=0, WQ_LEVEL=0, WQ_FULL=0, INT_WR_VALID=0, WQ_OVF=0, pointers 0.
REQ-038 Reset mid-strobe SHALL drop the strobe; after release with strobe still low, FSM SHALL re-enter from IDLE per REQ-023/024/026 (new push/capture).
REQ-039 Queue contents need not be cleared; INT_OUT_DATA is don't-care while empty.

Verification
REQ-040 Write 0xA5 (CS_N=0, WR_N low 3 cycles) -> exactly one push, WQ_LEVEL=1, INT_OUT_DATA=0xA5, INT_WR_VALID=1 next cycle.
REQ-041 Five writes 0x11..0x15, INT_WR_READY=0, depth 4 -> WQ_FULL=1, WQ_OVF=1, pops yield 0x11..0x14; CLR_OVF clears flag.
REQ-042 Read, INT_IN_DATA=0x3C at capture then 0xFF mid-strobe -> CPU_OE=1, CPU_OUT_DATA=0x3C until RD_N high, then CPU_OE=0.
REQ-043 CS_N=1, CAS_SEL=1, RD_N low, INT_IN_DATA=0x40 -> CPU_OE=1, CPU_OUT_DATA=0x40; CAS_SEL=0 -> no read.
REQ-044 RD_N and WR_N low together -> BUS_ERR=1, no push, CPU_OE=0 until both high.
REQ-045 Full queue, write with INT_WR_READY=1 same edge -> WQ_LEVEL stays 4, WQ_OVF=0, new data at tail; RST_N low mid-read -> CPU_OE=0 at once.

Source files
------------

// File: rtl/data_bus_buffer_q.sv
// CPU-side data bus buffer: strobe FSM, registered read capture, and a
// write queue that hands CPU writes to an internal consumer.
module data_bus_buffer_q #(
    parameter int DATA_W   = 8,
    parameter int WQ_DEPTH = 4,
    localparam int LVL_W   = $clog2(WQ_DEPTH + 1),
    localparam int PTR_W   = $clog2(WQ_DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CS_N,
    input  logic              RD_N,
    input  logic              WR_N,
    input  logic              CAS_SEL,
    input  logic [DATA_W-1:0] CPU_IN_DATA,
    output logic [DATA_W-1:0] CPU_OUT_DATA,
    output logic              CPU_OE,
    input  logic [DATA_W-1:0] INT_IN_DATA,
    output logic [DATA_W-1:0] INT_OUT_DATA,
    output logic              INT_WR_VALID,
    input  logic              INT_WR_READY,
    output logic [LVL_W-1:0]  WQ_LEVEL,
    output logic              WQ_FULL,
    output logic              WQ_OVF,
    input  logic              CLR_OVF,
    output logic              BUS_ERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ACT = 2'd1,
        WR_ACT = 2'd2,
        ERR    = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                push_req;
    logic                capture;

    logic [DATA_W-1:0]   cpu_out_data_q, cpu_out_data_d;
    logic [DATA_W-1:0]   mem_q [WQ_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                ovf_q, ovf_d;

    logic                full;
    logic                empty;
    logic                do_push;
    logic                do_pop;
    logic                ovf_set;

    // Strobe FSM: a push or capture is issued only on the edge that leaves
    // IDLE, so a long strobe produces exactly one transaction.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d  = state_q;
        push_req = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!RD_N && !WR_N) begin
                    state_d = ERR;
                end else if (!WR_N && !CS_N) begin
                    state_d  = WR_ACT;
                    push_req = 1'b1;
                end else if (!RD_N && (!CS_N || CAS_SEL)) begin
                    state_d = RD_ACT;
                    capture = 1'b1;
                end
            end
            WR_ACT: begin
                if (!RD_N) begin
                    state_d = ERR;
                end else if (WR_N) begin
                    state_d = IDLE;
                end
            end
            RD_ACT: begin
                if (!WR_N) begin
                    state_d = ERR;
                end else if (RD_N) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (RD_N && WR_N) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu_out_data_d = capture ? INT_IN_DATA : cpu_out_data_q;

    // Queue control: a push into a full queue still lands when the head
    // leaves on the same edge, because the tail slot is the one being freed.
    assign full    = (level_q == LVL_W'(WQ_DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = !empty && INT_WR_READY;
    assign do_push = push_req && (!full || do_pop);
    assign ovf_set = push_req && full && !do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Set wins over clear so an overflow on the clearing edge is not lost.
    assign ovf_d = ovf_set || (ovf_q && !CLR_OVF);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= IDLE;
            cpu_out_data_q <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            ovf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cpu_out_data_q <= cpu_out_data_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            ovf_q          <= ovf_d;
        end
    end

    // NOTE: queue storage is deliberately not reset; an empty queue's head
    // is never consumed, and leaving it out keeps the array as plain RAM.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= CPU_IN_DATA;
        end
    end

    assign CPU_OUT_DATA = cpu_out_data_q;
    assign CPU_OE       = (state_q == RD_ACT);
    assign BUS_ERR      = (state_q == ERR);
    assign INT_OUT_DATA = mem_q[rd_ptr_q];
    assign INT_WR_VALID = !empty;
    assign WQ_LEVEL     = level_q;
    assign WQ_FULL      = full;
    assign WQ_OVF       = ovf_q;

endmodule

// File: tb/tb_data_bus_buffer_q.sv
// Self-checking bench for data_bus_buffer_q: table-driven read vectors plus
// hand sequences for write queue, overflow, bus error and reset corners.
module tb_data_bus_buffer_q;

    localparam int DATA_W   = 8;
    localparam int WQ_DEPTH = 4;
    localparam int LVL_W    = $clog2(WQ_DEPTH + 1);

    logic              clk;
    logic              rst_n;
    logic              cs_n;
    logic              rd_n;
    logic              wr_n;
    logic              cas_sel;
    logic [DATA_W-1:0] cpu_in_data;
    logic [DATA_W-1:0] cpu_out_data;
    logic              cpu_oe;
    logic [DATA_W-1:0] int_in_data;
    logic [DATA_W-1:0] int_out_data;
    logic              int_wr_valid;
    logic              int_wr_ready;
    logic [LVL_W-1:0]  wq_level;
    logic              wq_full;
    logic              wq_ovf;
    logic              clr_ovf;
    logic              bus_err;

    data_bus_buffer_q #(
        .DATA_W   (DATA_W),
        .WQ_DEPTH (WQ_DEPTH)
    ) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .CS_N         (cs_n),
        .RD_N         (rd_n),
        .WR_N         (wr_n),
        .CAS_SEL      (cas_sel),
        .CPU_IN_DATA  (cpu_in_data),
        .CPU_OUT_DATA (cpu_out_data),
        .CPU_OE       (cpu_oe),
        .INT_IN_DATA  (int_in_data),
        .INT_OUT_DATA (int_out_data),
        .INT_WR_VALID (int_wr_valid),
        .INT_WR_READY (int_wr_ready),
        .WQ_LEVEL     (wq_level),
        .WQ_FULL      (wq_full),
        .WQ_OVF       (wq_ovf),
        .CLR_OVF      (clr_ovf),
        .BUS_ERR      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              cs_n;
        logic              cas_sel;
        logic [DATA_W-1:0] int_in;
        logic              exp_oe;
        logic [DATA_W-1:0] exp_data;
    } rd_vec_t;

    rd_vec_t           vecs [5];
    logic [DATA_W-1:0] sb [$];
    logic              exp_ovf;
    int                n_checks;
    int                n_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [DATA_W-1:0] d, input logic clr);
        cs_n        = 1'b0;
        wr_n        = 1'b0;
        cpu_in_data = d;
        clr_ovf     = clr;
        if (sb.size() < WQ_DEPTH) begin
            sb.push_back(d);
            exp_ovf = exp_ovf && !clr;
        end else begin
            exp_ovf = 1'b1;
        end
        tick();
        wr_n    = 1'b1;
        cs_n    = 1'b1;
        clr_ovf = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        logic [DATA_W-1:0] exp;
        check("pop_valid", int_wr_valid, 1);
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            check("pop_head", int_out_data, exp);
        end
        int_wr_ready = 1'b1;
        tick();
        int_wr_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks     = 0;
        n_err        = 0;
        exp_ovf      = 1'b0;
        rst_n        = 1'b0;
        cs_n         = 1'b1;
        rd_n         = 1'b1;
        wr_n         = 1'b1;
        cas_sel      = 1'b0;
        cpu_in_data  = '0;
        int_in_data  = '0;
        int_wr_ready = 1'b0;
        clr_ovf      = 1'b0;

        vecs[0] = '{cs_n: 1'b1, cas_sel: 1'b1, int_in: 8'h40, exp_oe: 1'b1, exp_data: 8'h40};
        vecs[1] = '{cs_n: 1'b1, cas_sel: 1'b0, int_in: 8'h77, exp_oe: 1'b0, exp_data: 8'h40};
        vecs[2] = '{cs_n: 1'b0, cas_sel: 1'b0, int_in: 8'h5A, exp_oe: 1'b1, exp_data: 8'h5A};
        vecs[3] = '{cs_n: 1'b0, cas_sel: 1'b1, int_in: 8'hC3, exp_oe: 1'b1, exp_data: 8'hC3};
        vecs[4] = '{cs_n: 1'b1, cas_sel: 1'b0, int_in: 8'h00, exp_oe: 1'b0, exp_data: 8'hC3};

        // Reset state
        #1;
        check("rst_oe", cpu_oe, 0);
        check("rst_data", cpu_out_data, 0);
        check("rst_err", bus_err, 0);
        check("rst_level", wq_level, 0);
        check("rst_full", wq_full, 0);
        check("rst_valid", int_wr_valid, 0);
        check("rst_ovf", wq_ovf, 0);
        #11;
        rst_n = 1'b1;
        tick();

        // Long write strobe pushes exactly once
        cs_n        = 1'b0;
        wr_n        = 1'b0;
        cpu_in_data = 8'hA5;
        sb.push_back(8'hA5);
        tick();
        check("wr_level", wq_level, 1);
        check("wr_valid", int_wr_valid, 1);
        check("wr_head", int_out_data, 8'hA5);
        tick();
        tick();
        check("wr_hold_level", wq_level, 1);
        wr_n = 1'b1;
        cs_n = 1'b1;
        tick();
        pop_one();
        check("wr_pop_level", wq_level, 0);
        check("wr_pop_valid", int_wr_valid, 0);

        // Overflow with five writes into a four-deep queue
        for (int i = 0; i < 5; i++) begin
            do_write(8'(8'h11 + i), 1'b0);
        end
        check("ovf_full", wq_full, 1);
        check("ovf_flag", wq_ovf, exp_ovf);
        check("ovf_level", wq_level, sb.size());
        for (int i = 0; i < 4; i++) begin
            pop_one();
        end
        check("ovf_drained", wq_level, 0);
        check("ovf_sticky", wq_ovf, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        exp_ovf = 1'b0;
        check("ovf_clear", wq_ovf, exp_ovf);

        // Ready on empty queue does nothing
        int_wr_ready = 1'b1;
        tick();
        int_wr_ready = 1'b0;
        check("empty_pop_level", wq_level, 0);
        check("empty_pop_valid", int_wr_valid, 0);

        // Read capture ignores later internal data changes
        int_in_data = 8'h3C;
        cs_n        = 1'b0;
        rd_n        = 1'b0;
        tick();
        check("rd_oe", cpu_oe, 1);
        check("rd_data", cpu_out_data, 8'h3C);
        int_in_data = 8'hFF;
        tick();
        tick();
        check("rd_hold_oe", cpu_oe, 1);
        check("rd_hold_data", cpu_out_data, 8'h3C);
        rd_n = 1'b1;
        cs_n = 1'b1;
        tick();
        check("rd_end_oe", cpu_oe, 0);
        check("rd_end_data", cpu_out_data, 8'h3C);

        // Table-driven read selects (cascade and chip select)
        for (int i = 0; i < 5; i++) begin
            cs_n        = vecs[i].cs_n;
            cas_sel     = vecs[i].cas_sel;
            int_in_data = vecs[i].int_in;
            rd_n        = 1'b0;
            tick();
            check($sformatf("vec%0d_oe", i), cpu_oe, vecs[i].exp_oe);
            check($sformatf("vec%0d_data", i), cpu_out_data, vecs[i].exp_data);
            rd_n    = 1'b1;
            cs_n    = 1'b1;
            cas_sel = 1'b0;
            tick();
            check($sformatf("vec%0d_release_oe", i), cpu_oe, 0);
            check($sformatf("vec%0d_retain", i), cpu_out_data, vecs[i].exp_data);
        end
        check("vec_no_push", wq_level, 0);

        // Both strobes low: error until both high, no push
        cs_n        = 1'b0;
        rd_n        = 1'b0;
        wr_n        = 1'b0;
        cpu_in_data = 8'hEE;
        tick();
        check("err_flag", bus_err, 1);
        check("err_oe", cpu_oe, 0);
        check("err_level", wq_level, 0);
        wr_n = 1'b1;
        tick();
        check("err_hold", bus_err, 1);
        check("err_hold_oe", cpu_oe, 0);
        rd_n = 1'b1;
        tick();
        check("err_exit", bus_err, 0);

        // Write strobe then read strobe: one push, then error
        wr_n        = 1'b0;
        cpu_in_data = 8'h5C;
        sb.push_back(8'h5C);
        tick();
        rd_n = 1'b0;
        tick();
        check("wr_err_flag", bus_err, 1);
        check("wr_err_level", wq_level, 1);
        rd_n = 1'b1;
        wr_n = 1'b1;
        cs_n = 1'b1;
        tick();
        check("wr_err_exit", bus_err, 0);
        pop_one();

        // Read strobe then write strobe: error drops output enable
        cs_n        = 1'b0;
        rd_n        = 1'b0;
        int_in_data = 8'h12;
        tick();
        check("rd_err_oe_pre", cpu_oe, 1);
        wr_n = 1'b0;
        tick();
        check("rd_err_flag", bus_err, 1);
        check("rd_err_oe", cpu_oe, 0);
        check("rd_err_level", wq_level, 0);
        rd_n = 1'b1;
        wr_n = 1'b1;
        cs_n = 1'b1;
        tick();
        check("rd_err_exit", bus_err, 0);

        // Full queue, push and pop on the same edge
        for (int i = 0; i < 4; i++) begin
            do_write(8'(8'h21 + i), 1'b0);
        end
        check("pp_full_pre", wq_full, 1);
        cs_n         = 1'b0;
        wr_n         = 1'b0;
        cpu_in_data  = 8'h25;
        int_wr_ready = 1'b1;
        check("pp_head", int_out_data, sb.pop_front());
        sb.push_back(8'h25);
        tick();
        wr_n         = 1'b1;
        cs_n         = 1'b1;
        int_wr_ready = 1'b0;
        check("pp_level", wq_level, 4);
        check("pp_ovf", wq_ovf, 0);
        check("pp_full", wq_full, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            pop_one();
        end
        check("pp_drained", wq_level, 0);

        // Overflow on the same edge as a clear leaves the flag set
        for (int i = 0; i < 4; i++) begin
            do_write(8'(8'h31 + i), 1'b0);
        end
        do_write(8'h35, 1'b1);
        check("setclr_ovf", wq_ovf, exp_ovf);
        for (int i = 0; i < 4; i++) begin
            pop_one();
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        exp_ovf = 1'b0;
        check("setclr_cleared", wq_ovf, exp_ovf);

        // Reset mid-read drops output enable at once, then re-captures
        do_write(8'h70, 1'b0);
        check("rstrd_level_pre", wq_level, 1);
        cs_n        = 1'b0;
        rd_n        = 1'b0;
        int_in_data = 8'h99;
        tick();
        check("rstrd_oe_pre", cpu_oe, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rstrd_oe", cpu_oe, 0);
        check("rstrd_data", cpu_out_data, 0);
        check("rstrd_level", wq_level, 0);
        check("rstrd_valid", int_wr_valid, 0);
        sb.delete();
        int_in_data = 8'h66;
        #1 rst_n = 1'b1;
        tick();
        check("rstrd_recapture_oe", cpu_oe, 1);
        check("rstrd_recapture_data", cpu_out_data, 8'h66);
        rd_n = 1'b1;
        cs_n = 1'b1;
        tick();
        check("rstrd_end_oe", cpu_oe, 0);

        // Reset mid-write, strobe still low afterwards pushes again
        cs_n        = 1'b0;
        wr_n        = 1'b0;
        cpu_in_data = 8'h80;
        tick();
        check("rstwr_level_pre", wq_level, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rstwr_level", wq_level, 0);
        cpu_in_data = 8'h81;
        sb.push_back(8'h81);
        #1 rst_n = 1'b1;
        tick();
        check("rstwr_repush", wq_level, 1);
        wr_n = 1'b1;
        cs_n = 1'b1;
        tick();
        pop_one();
        check("rstwr_drained", wq_level, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
